chien_ctrl: RTL and testbench
=============================

CHIEN_CTRL -- requirements
Module: chien_ctrl

Interface
REQ-001 SHALL have parameter M, default 4: field degree; also the width of the position counter and the error count.
REQ-002 SHALL have parameter T, default 3: maximum correctable errors; sig_deg range 0..T.
REQ-003 SHALL have parameter N, default 2^M-1: number of codeword positions searched; 1 <= N <= 2^M-1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port sig_valid, input, 1: upstream presents a locator polynomial; upstream drives the coefficients to the Chien datapath directly.
REQ-007 SHALL have port sig_deg, input, ceil(log2(T+1)): degree of the presented locator polynomial.
REQ-008 SHALL have port sig_ready, output, 1: controller can accept a polynomial.
REQ-009 SHALL have port ch_start, output, 1: load strobe to the Chien datapath.
REQ-010 SHALL have port cei, output, 1: step enable to the Chien datapath.
REQ-011 SHALL have port chien_err, input, 1: root-found flag from the Chien datapath for the current position.
REQ-012 SHALL have port bit_ready, input, 1: downstream accepts the current error flag.
REQ-013 SHALL have port err_valid, output, 1: err_bit and err_last are valid.
REQ-014 SHALL have port err_bit, output, 1: error flag for the current position.
REQ-015 SHALL have port err_last, output, 1: the current position is N-1.
REQ-016 SHALL have port done, output, 1: one-cycle end-of-search pulse.
REQ-017 SHALL have port fail, output, 1: uncorrectable result (root count differs from degree).
REQ-018 SHALL have port err_count, output, M: number of roots found in the last or current search.

Function
REQ-019 SHALL implement the FSM states IDLE, SEARCH and FINISH.
REQ-020 SHALL assert sig_ready only in IDLE; accept = sig_valid & sig_ready; ch_start = accept (combinational, same cycle).
REQ-021 SHALL, on accept, latch sig_deg, clear the position counter and err_count, clear fail, and enter SEARCH on the next cycle.
REQ-022 SHALL hold err_valid = 1 throughout SEARCH; transfer = err_valid & bit_ready; cei = transfer, except as REQ-033 modifies it.
REQ-023 SHALL drive err_bit = chien_err; err_last = (position == N-1).
REQ-024 SHALL, on each transfer, increment the position counter and increment err_count when err_bit is 1.
REQ-025 SHALL hold the position, cei and counters while bit_ready is 0, with no limit on stall length.
REQ-026 SHALL move from SEARCH to FINISH on the transfer with err_last = 1.
REQ-027 SHALL, in FINISH, assert done for one cycle and register fail = (final err_count != latched degree), then return to IDLE.
REQ-028 SHALL hold fail and err_count stable from FINISH until the next accept.
REQ-029 SHALL keep sig_ready low in FINISH: no accept coincides with done, so the minimum gap between accepts is N+2 cycles.
REQ-030 SHALL ignore sig_valid outside IDLE.
REQ-031 SHALL, with sig_deg = 0, still run all N positions.

Reset
REQ-032 SHALL, with reset high on any cycle including mid-SEARCH, enter IDLE on the next edge with:
- err_valid, cei, done, fail, err_count and the position counter all 0;
- sig_ready = 1;
- no done pulse for the aborted search.

Configuration
REQ-033 SHALL, with CHIEN_CTRL_EARLY_EXIT_EN defined, force cei = 0 and err_bit = 0 once err_count equals the latched degree; err_valid still covers all N positions and done timing is unchanged.
REQ-034 SHALL, without CHIEN_CTRL_EARLY_EXIT_EN, step cei on every transfer for all N positions.

Verification (M=4, T=3, N=15, stub chien_err model)
REQ-035 SHALL cover: accept at cycle 0, deg 0, chien_err 0, bit_ready 1 -> 15 transfers in cycles 1-15, all err_bit 0; done at cycle 16; fail=0; err_count=0.
REQ-036 SHALL cover: deg 2, roots at positions 3 and 9 -> err_bit=1 on transfers 3 and 9; err_count=2; fail=0.
REQ-037 SHALL cover: deg 3, single root at position 4 -> err_count=1; fail=1 at done.
REQ-038 SHALL cover: bit_ready=0 on cycles 5-7 -> cei=0 and position held for those cycles; still 15 transfers; done at cycle 19.
REQ-039 SHALL cover: reset at position 6 -> next cycle IDLE, sig_ready=1, err_valid=0, no done pulse; a new accept then runs normally.
REQ-040 SHALL cover, with CHIEN_CTRL_EARLY_EXIT_EN: deg 1, root at position 2 -> cei=0 for positions 3-14, err_bit=0 there, 15 err_valid transfers, done at cycle 16.

Source files
------------

// File: rtl/chien_ctrl.sv
// Control FSM for a Chien search datapath. It sequences N positions, streams error flags and counts roots.
// Optional feature: define CHIEN_CTRL_EARLY_EXIT_EN to stop stepping the datapath once all expected roots are found.
module chien_ctrl #(
  parameter int M = 4,
  parameter int T = 3,
  parameter int N = (1 << M) - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sig_valid,
  input  logic [$clog2(T+1)-1:0]        sig_deg,
  output logic                          sig_ready,
  output logic                          ch_start,
  output logic                          cei,
  input  logic                          chien_err,
  input  logic                          bit_ready,
  output logic                          err_valid,
  output logic                          err_bit,
  output logic                          err_last,
  output logic                          done,
  output logic                          fail,
  output logic [M-1:0]                  err_count,
  output logic [1:0]                    dbg_state
);

  localparam int DW = $clog2(T+1);
  localparam logic [M-1:0] ONE      = M'(1);
  localparam logic [M-1:0] LAST_POS = M'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e          state_q;
  logic [M-1:0]    pos_q;
  logic [M-1:0]    cnt_q;
  logic [M-1:0]    cnt_d;
  logic [DW-1:0]   deg_q;
  logic            fail_q;
  logic            done_q;

  logic            accept;
  logic            in_search;
  logic            transfer;
  logic            last_pos;
  logic            exhausted;
  logic [M-1:0]    deg_ext;

  // Handshakes: an item moves when valid and ready are both high in the same
  // cycle; a producer holding valid keeps its data stable until it moves.
  always_comb begin
    in_search = (state_q == S_SEARCH);
    accept    = sig_valid & (state_q == S_IDLE);
    deg_ext   = M'(deg_q);
    last_pos  = (pos_q == LAST_POS);
`ifdef CHIEN_CTRL_EARLY_EXIT_EN
    exhausted = (cnt_q == deg_ext);
`else
    exhausted = 1'b0;
`endif
    transfer  = in_search & bit_ready;
    cnt_d     = (transfer && err_bit) ? cnt_q + ONE : cnt_q;
  end

  assign sig_ready = (state_q == S_IDLE);
  assign ch_start  = accept;
  assign err_valid = in_search;
  assign err_bit   = chien_err & ~exhausted;
  assign err_last  = in_search & last_pos;
  assign cei       = transfer & ~exhausted;
  assign done      = done_q;
  assign fail      = fail_q;
  assign err_count = cnt_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      deg_q   <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            deg_q   <= sig_deg;
            pos_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            state_q <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (transfer) begin
            pos_q <= pos_q + ONE;
            cnt_q <= cnt_d;
            // Verdict is registered alongside done so both appear in FINISH.
            if (last_pos) begin
              fail_q  <= (cnt_d != deg_ext);
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chien_ctrl.sv
// Directed bench for chien_ctrl (M=4, T=3, N=15) with a stub Chien datapath driven by cei/ch_start.
module tb_chien_ctrl;

  logic        clk;
  logic        reset;
  logic        sig_valid;
  logic [1:0]  sig_deg;
  logic        sig_ready;
  logic        ch_start;
  logic        cei;
  logic        chien_err;
  logic        bit_ready;
  logic        err_valid;
  logic        err_bit;
  logic        err_last;
  logic        done;
  logic        fail;
  logic [3:0]  err_count;
  logic [1:0]  dbg_state;

  logic [15:0] root_mask;
  logic [3:0]  stub_pos;
  int          n_checks;
  int          n_fail;
  bit          early;

  chien_ctrl #(.M(4), .T(3), .N(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_valid (sig_valid),
    .sig_deg   (sig_deg),
    .sig_ready (sig_ready),
    .ch_start  (ch_start),
    .cei       (cei),
    .chien_err (chien_err),
    .bit_ready (bit_ready),
    .err_valid (err_valid),
    .err_bit   (err_bit),
    .err_last  (err_last),
    .done      (done),
    .fail      (fail),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub datapath: evaluates position stub_pos, reloads on ch_start, steps on cei
  always @(posedge clk) begin
    if (reset || ch_start) stub_pos <= 4'd0;
    else if (cei)          stub_pos <= stub_pos + 4'd1;
  end
  assign chien_err = root_mask[stub_pos];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One search: accept at cycle 0, bit_ready low on cycles st_lo..st_hi,
  // optional reset while the expected position equals abort_pos.
  task automatic run_search(input int deg, input logic [15:0] mask, input int st_lo,
                            input int st_hi, input int abort_pos, input bit pester,
                            input int exp_done_cycle);
    int  exp_pos;
    int  exp_cnt;
    int  c;
    bit  exh;
    bit  eb;
    root_mask = mask;
    sig_valid = 1'b1;
    sig_deg   = 2'(deg);
    bit_ready = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(sig_ready), 32'd1);
    check("accept_start", 32'(ch_start), 32'd1);
    tick();
    sig_valid = pester;
    exp_pos = 0;
    exp_cnt = 0;
    c = 1;
    while (exp_pos < 15 && c < 60) begin
      bit_ready = !(c >= st_lo && c <= st_hi);
      if (exp_pos == abort_pos) begin
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        sig_valid = 1'b0;
        bit_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_ready", 32'(sig_ready), 32'd1);
          check("abort_valid", 32'(err_valid), 32'd0);
          check("abort_cei", 32'(cei), 32'd0);
          check("abort_done", 32'(done), 32'd0);
          check("abort_fail", 32'(fail), 32'd0);
          check("abort_count", 32'(err_count), 32'd0);
          check("abort_state", 32'(dbg_state), 32'd0);
          tick();
        end
        return;
      end
      exh = early && (exp_cnt == deg);
      eb  = mask[exp_pos] && !exh;
      @(negedge clk);
      check("srch_valid", 32'(err_valid), 32'd1);
      check("srch_bit", 32'(err_bit), 32'(eb));
      check("srch_last", 32'(err_last), 32'(exp_pos == 14));
      check("srch_cei", 32'(cei), 32'(bit_ready && !exh));
      check("srch_start", 32'(ch_start), 32'd0);
      check("srch_ready", 32'(sig_ready), 32'd0);
      check("srch_done", 32'(done), 32'd0);
      if (bit_ready) begin
        exp_pos++;
        if (eb) exp_cnt++;
      end
      tick();
      c++;
    end
    if (exp_pos < 15) check("search_timeout", 32'(exp_pos), 32'd15);
    sig_valid = 1'b0;
    bit_ready = 1'b1;
    @(negedge clk);
    check("fin_done", 32'(done), 32'd1);
    check("fin_cycle", 32'(c), 32'(exp_done_cycle));
    check("fin_fail", 32'(fail), 32'(exp_cnt != deg));
    check("fin_count", 32'(err_count), 32'(exp_cnt));
    check("fin_valid", 32'(err_valid), 32'd0);
    check("fin_ready", 32'(sig_ready), 32'd0);
    tick();
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_ready", 32'(sig_ready), 32'd1);
    check("idle_fail", 32'(fail), 32'(exp_cnt != deg));
    check("idle_count", 32'(err_count), 32'(exp_cnt));
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
`ifdef CHIEN_CTRL_EARLY_EXIT_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    reset     = 1'b1;
    sig_valid = 1'b0;
    sig_deg   = 2'd0;
    bit_ready = 1'b1;
    root_mask = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(sig_ready), 32'd1);
    check("rst_valid", 32'(err_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_cei", 32'(cei), 32'd0);
    tick();

    // deg 0, no roots: done at cycle 16
    run_search(0, 16'h0000, 100, 100, -1, 1'b0, 16);
    // deg 2, roots 3 and 9, sig_valid held high during search
    run_search(2, 16'h0208, 100, 100, -1, 1'b1, 16);
    // deg 3, one root at 4: fail
    run_search(3, 16'h0010, 100, 100, -1, 1'b0, 16);
    // stall cycles 5..7: done at cycle 19
    run_search(1, 16'h0800, 5, 7, -1, 1'b0, 19);
    // reset at position 6, then a fresh search
    run_search(2, 16'h0004, 100, 100, 6, 1'b0, 16);
    run_search(0, 16'h0000, 100, 100, -1, 1'b0, 16);
    // deg 1, root at 2 (early-exit case when enabled)
    run_search(1, 16'h0004, 100, 100, -1, 1'b0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
